clk_edge_monitor: RTL and testbench

- Receiving-side companion to the modulator's clock divider.
- Samples the divided clock `i_sclk` in the fast `i_clk` domain and emits single-cycle rise/fall strobes for downstream clock-enable use.
- Measures each half-period and checks it against the divider's nominal value. Declares lock after a run of correct half-periods.
- Flags period errors and loss of toggling.

---
 rtl/clk_edge_monitor.sv | 153 +++++++++++++++
 tb/tb_clk_edge_monitor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_edge_monitor.sv
// Divided-clock edge monitor: one-cycle rise/fall strobes, half-period measurement,
// lock acquisition against the nominal divider period, and loss-of-toggle detection.
module clk_edge_monitor #(
    parameter int NBITS    = 3,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sclk,
    output logic             o_rise,
    output logic             o_fall,
    output logic [CNT_W-1:0] o_half_period,
    output logic             o_locked,
    output logic             o_err,
    output logic             o_timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] NOMINAL = CNT_W'(2 ** NBITS);
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);

    generate
        if ((64'd1 << NBITS) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_nbits
            $error("clk_edge_monitor: 2**NBITS must not exceed 2**CNT_W-1");
        end
        if (LOCK_CNT < 1 || LOCK_CNT > 15) begin : g_bad_lock
            $error("clk_edge_monitor: LOCK_CNT must be in 1..15");
        end
    endgenerate

    state_t           state, next_state;
    logic             sclk_q;
    logic             rise, fall, sclk_edge;
    logic [CNT_W-1:0] cnt, cnt_inc, meas;
    logic             good, at_timeout;
    logic [3:0]       match, match_inc;

    logic [CNT_W-1:0] cnt_d, half_d;
    logic [3:0]       match_d;
    logic             locked_d, err_d, timeout_d;

    assign rise      = i_sclk & ~sclk_q;
    assign fall      = ~i_sclk & sclk_q;
    assign sclk_edge = rise | fall;

    assign cnt_inc    = (cnt == MAX) ? MAX : cnt + 1'b1;
    assign meas       = cnt_inc;
    assign good       = (meas == NOMINAL);
    assign match_inc  = match + 4'd1;
    // Counter is about to saturate with no edge this cycle: toggling has stopped.
    assign at_timeout = !sclk_edge && (cnt == (MAX - 1'b1));
    assign cnt_d      = sclk_edge ? '0 : cnt_inc;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (sclk_edge) next_state = ACQ;
            end
            ACQ: begin
                if (sclk_edge) begin
                    if (good && match_inc == LOCK_N) next_state = LOCKED;
                end else if (at_timeout) begin
                    next_state = IDLE;
                end
            end
            LOCKED: begin
                if (sclk_edge) begin
                    if (!good) next_state = ACQ;
                end else if (at_timeout) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        match_d   = match;
        half_d    = o_half_period;
        err_d     = 1'b0;
        timeout_d = 1'b0;
        locked_d  = (next_state == LOCKED);
        unique case (state)
            IDLE: begin
                if (sclk_edge) match_d = '0;
            end
            ACQ: begin
                if (sclk_edge) begin
                    half_d  = meas;
                    match_d = good ? match_inc : 4'd0;
                end else if (at_timeout) begin
                    timeout_d = 1'b1;
                    match_d   = '0;
                end
            end
            LOCKED: begin
                if (sclk_edge) begin
                    half_d = meas;
                    if (!good) begin
                        err_d   = 1'b1;
                        match_d = '0;
                    end
                end else if (at_timeout) begin
                    timeout_d = 1'b1;
                    match_d   = '0;
                end
            end
            default: match_d = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sclk_q        <= 1'b0;
            cnt           <= '0;
            match         <= '0;
            o_rise        <= 1'b0;
            o_fall        <= 1'b0;
            o_half_period <= '0;
            o_locked      <= 1'b0;
            o_err         <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            sclk_q        <= i_sclk;
            cnt           <= cnt_d;
            match         <= match_d;
            o_rise        <= rise;
            o_fall        <= fall;
            o_half_period <= half_d;
            o_locked      <= locked_d;
            o_err         <= err_d;
            o_timeout     <= timeout_d;
        end
    end

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Self-checking bench for clk_edge_monitor: directed scenarios plus random half-periods,
// compared every cycle against an interval-based model of the monitor.
module tb_clk_edge_monitor;

    localparam int NBITS    = 3;
    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 4;
    localparam int NOM      = 1 << NBITS;
    localparam int MAXV     = (1 << CNT_W) - 1;

    logic             i_clk;
    logic             i_rst;
    logic             i_sclk;
    logic             o_rise, o_fall, o_locked, o_err, o_timeout;
    logic [CNT_W-1:0] o_half_period;

    clk_edge_monitor #(.NBITS(NBITS), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_sclk        (i_sclk),
        .o_rise        (o_rise),
        .o_fall        (o_fall),
        .o_half_period (o_half_period),
        .o_locked      (o_locked),
        .o_err         (o_err),
        .o_timeout     (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: tracks elapsed cycles between observed edges as a plain integer.
    logic m_prev, m_track, m_locked;
    int   m_gap, m_run;
    logic e_rise, e_fall, e_locked, e_err, e_to;
    int   e_half;

    task automatic model_reset();
        m_prev = 1'b0; m_track = 1'b0; m_locked = 1'b0;
        m_gap = 0; m_run = 0;
        e_rise = 1'b0; e_fall = 1'b0; e_locked = 1'b0; e_err = 1'b0; e_to = 1'b0;
        e_half = 0;
    endtask

    task automatic model_step(input logic lvl);
        logic is_edge;
        int   hp;
        is_edge = (lvl != m_prev);
        m_prev  = lvl;
        e_rise  = is_edge && lvl;
        e_fall  = is_edge && !lvl;
        e_err   = 1'b0;
        e_to    = 1'b0;
        m_gap++;
        if (is_edge) begin
            if (m_track) begin
                hp     = (m_gap > MAXV) ? MAXV : m_gap;
                e_half = hp;
                if (m_locked) begin
                    if (hp != NOM) begin
                        e_err = 1'b1; m_locked = 1'b0; m_run = 0;
                    end
                end else begin
                    m_run = (hp == NOM) ? m_run + 1 : 0;
                    if (m_run == LOCK_CNT) m_locked = 1'b1;
                end
            end else begin
                m_track = 1'b1;
                m_run   = 0;
            end
            m_gap = 0;
        end else if (m_track && m_gap == MAXV) begin
            e_to = 1'b1; m_track = 1'b0; m_locked = 1'b0; m_run = 0;
        end
        e_locked = m_locked;
    endtask

    // Observed DUT event bookkeeping, compared against literals by the directed scenarios.
    int   cyc = 0;
    int   edge_count = 0, lock_edge = 0, last_edge_cyc = 0, to_gap = 0;
    int   to_count = 0, err_count = 0;
    logic locked_prev = 1'b0;

    always @(posedge i_clk) begin
        cyc++;
        if (i_rst) model_step(i_sclk);
        #1;
        if (i_rst) begin
            check("rise",        32'(o_rise),        32'(e_rise));
            check("fall",        32'(o_fall),        32'(e_fall));
            check("half_period", 32'(o_half_period), 32'(e_half));
            check("locked",      32'(o_locked),      32'(e_locked));
            check("err",         32'(o_err),         32'(e_err));
            check("timeout",     32'(o_timeout),     32'(e_to));
            if (o_rise || o_fall) begin
                edge_count++;
                last_edge_cyc = cyc;
            end
            if (o_locked && !locked_prev) lock_edge = edge_count;
            locked_prev = o_locked;
            if (o_timeout) begin
                to_count++;
                to_gap = cyc - last_edge_cyc;
            end
            if (o_err) err_count++;
        end
    end

    // Toggle i_sclk now (at a negedge), then hold it for n cycles.
    task automatic half_period(input int n);
        i_sclk = ~i_sclk;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rise"},    32'(o_rise),        32'd0);
        check({tag, "_fall"},    32'(o_fall),        32'd0);
        check({tag, "_half"},    32'(o_half_period), 32'd0);
        check({tag, "_locked"},  32'(o_locked),      32'd0);
        check({tag, "_err"},     32'(o_err),         32'd0);
        check({tag, "_timeout"}, 32'(o_timeout),     32'd0);
    endtask

    task automatic fresh_start();
        edge_count  = 0;
        lock_edge   = 0;
        locked_prev = 1'b0;
    endtask

    int e0, t0;

    initial begin
        i_rst  = 1'b1;
        i_sclk = 1'b0;
        model_reset();
        #2 i_rst = 1'b0;
        model_reset();
        #1 check_all_zero("por");
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        fresh_start();
        repeat (2) @(negedge i_clk);

        // 1: nominal toggling from reset; lock on the 5th edge.
        repeat (10) half_period(NOM);
        check("s1_lock_edge", 32'(lock_edge), 32'd5);
        check("s1_locked",    32'(o_locked), 32'd1);
        check("s1_half",      32'(o_half_period), 32'd8);

        // 2: one 9-cycle half-period while locked, then relock.
        e0 = err_count;
        half_period(9);
        repeat (4) half_period(NOM);
        check("s2_unlocked", 32'(o_locked), 32'd0);
        half_period(NOM);
        check("s2_relocked", 32'(o_locked), 32'd1);
        check("s2_err_once", 32'(err_count - e0), 32'd1);

        // 3: freeze while locked -> timeout 255 cycles after the last edge.
        t0 = to_count;
        repeat (300) @(negedge i_clk);
        check("s3_timeouts", 32'(to_count - t0), 32'd1);
        check("s3_to_gap",   32'(to_gap), 32'd255);
        check("s3_locked",   32'(o_locked), 32'd0);
        half_period(NOM);
        check("s3_no_update", 32'(o_half_period), 32'd8);
        repeat (4) half_period(NOM);
        check("s3_relocked", 32'(o_locked), 32'd1);

        // 4: match=3 in ACQ, then a 7-cycle half-period restarts acquisition.
        repeat (300) @(negedge i_clk);
        e0 = err_count;
        repeat (3) half_period(NOM);
        half_period(7);
        repeat (4) half_period(NOM);
        check("s4_not_yet", 32'(o_locked), 32'd0);
        half_period(NOM);
        check("s4_locked",  32'(o_locked), 32'd1);
        check("s4_no_err",  32'(err_count - e0), 32'd0);

        // 5: asynchronous reset mid-cycle while locked.
        @(posedge i_clk);
        #2 i_rst = 1'b0;
        model_reset();
        #1 check_all_zero("arst");
        i_sclk = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        fresh_start();
        repeat (2) @(negedge i_clk);
        repeat (10) half_period(NOM);
        check("s5_lock_edge", 32'(lock_edge), 32'd5);
        check("s5_locked",    32'(o_locked), 32'd1);

        // 6: edge exactly as the counter saturates, then one interval past it.
        e0 = err_count;
        t0 = to_count;
        half_period(MAXV);
        half_period(NOM);
        check("s6_half",       32'(o_half_period), 32'd255);
        check("s6_no_timeout", 32'(to_count - t0), 32'd0);
        check("s6_err",        32'(err_count - e0), 32'd1);
        half_period(MAXV + 1);
        check("s6_timeout",    32'(to_count - t0), 32'd1);
        check("s6_half_hold",  32'(o_half_period), 32'd8);

        // Random half-periods, biased toward nominal so lock is reached and lost.
        for (int i = 0; i < 150; i++) begin
            int sel, n;
            sel = int'($urandom_range(0, 9));
            if (sel < 5)       n = NOM;
            else if (sel == 5) n = NOM - 1;
            else if (sel == 6) n = NOM + 1;
            else               n = int'($urandom_range(1, 40));
            half_period(n);
        end
        repeat (20) @(negedge i_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
